// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule_seq
// Description : Sequential AES-128/192/256 key expansion with a shared SubWord
//               and a registered 128-bit round-key read port.
//               Build option AES_KS_DEC_ORDER_EN reverses the read index.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule_seq #(
    parameter int NB     = 4,
    parameter int MAX_NK = 8,
    parameter int MAX_NR = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  key_ready,
    output logic                  err,
    output logic [3:0]            nr_out,
    input  logic [3:0]            rk_idx,
    output logic [32*NB-1:0]      rk_out
);

    localparam int c_WORDS = NB * (MAX_NR + 1);
    localparam int c_IW    = $clog2(c_WORDS);

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    // Byte x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [32*MAX_NK-1:0]   r_key;
    logic [3:0]             r_nk;
    logic [3:0]             r_nr;
    logic [3:0]             r_j;
    logic [7:0]             r_rcon;
    logic [c_IW-1:0]        r_i;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_key_ready;
    logic                   r_err;
    logic [32*NB-1:0]       r_rk;
    logic [31:0]            r_mem [c_WORDS];

    logic [3:0]             w_nk;
    logic [3:0]             w_nr;
    logic [31:0]            w_prev;
    logic [31:0]            w_old;
    logic [31:0]            w_sub;
    logic [31:0]            w_t;
    logic [31:0]            w_new;
    logic [c_IW-1:0]        w_last;
    logic [3:0]             w_rd_k;
    logic                   w_rd_ok;
    logic [c_IW-1:0]        w_rd_base;

    always_comb begin
        w_nk = 4'd8;
        w_nr = 4'd14;
        case (key_len)
            2'b00:   begin w_nk = 4'd4; w_nr = 4'd10; end
            2'b01:   begin w_nk = 4'd6; w_nr = 4'd12; end
            default: begin w_nk = 4'd8; w_nr = 4'd14; end
        endcase
    end

    assign w_prev = r_mem[r_i - c_IW'(1)];
    assign w_old  = r_mem[r_i - c_IW'(r_nk)];
    assign w_sub  = sub_word((r_j == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign w_last = c_IW'({r_nr, 2'b11});

    always_comb begin
        w_t = w_prev;
        if (r_j == 4'd0)
            w_t = w_sub ^ {r_rcon, 24'h0};
        else if (r_nk == 4'd8 && r_j == 4'd4)
            w_t = w_sub;
    end

    assign w_new = w_old ^ w_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_nk        <= 4'd0;
            r_nr        <= 4'd0;
            r_j         <= 4'd0;
            r_rcon      <= 8'h00;
            r_i         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_ready <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == 2'b11) begin
                            r_err <= 1'b1;
                        end else begin
                            r_key       <= key_in;
                            r_nk        <= w_nk;
                            r_nr        <= w_nr;
                            r_key_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_i     <= c_IW'(r_nk);
                    r_j     <= 4'd0;
                    r_rcon  <= 8'h01;
                    r_state <= S_EXPAND;
                end
                S_EXPAND: begin
                    r_i <= r_i + c_IW'(1);
                    r_j <= (r_j == r_nk - 4'd1) ? 4'd0 : r_j + 4'd1;
                    if (r_j == 4'd0)
                        r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                    if (r_i == w_last) begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_key_ready <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Schedule storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (k < int'(r_nk))
                    r_mem[k] <= r_key[32*(MAX_NK-k)-1 -: 32];
            end
        end else if (r_state == S_EXPAND) begin
            r_mem[r_i] <= w_new;
        end
    end

`ifdef AES_KS_DEC_ORDER_EN
    assign w_rd_k = r_nr - rk_idx;
`else
    assign w_rd_k = rk_idx;
`endif

    assign w_rd_ok   = r_key_ready && (rk_idx <= r_nr);
    assign w_rd_base = w_rd_ok ? c_IW'({w_rd_k, 2'b00}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk <= '0;
        end else if (w_rd_ok) begin
            r_rk <= {r_mem[w_rd_base], r_mem[w_rd_base + c_IW'(1)],
                     r_mem[w_rd_base + c_IW'(2)], r_mem[w_rd_base + c_IW'(3)]};
        end else begin
            r_rk <= '0;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign key_ready = r_key_ready;
    assign err       = r_err;
    assign nr_out    = r_nr;
    assign rk_out    = r_rk;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_schedule_seq
// Description : Scoreboard bench for aes_key_schedule_seq using FIPS-197 keys.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule_seq;

    localparam logic [127:0] c_K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] c_K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] c_K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_R2_128  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] c_R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_R1_192  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] c_R12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] c_R1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_R2_256  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] c_R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

`ifdef AES_KS_DEC_ORDER_EN
    localparam bit c_DEC = 1'b1;
`else
    localparam bit c_DEC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic         err;
    logic [3:0]   nr_out;
    logic [127:0] rk_out;

    aes_key_schedule_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_len   (key_len),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .key_ready (key_ready),
        .err       (err),
        .nr_out    (nr_out),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int nr;
    } done_t;

    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    done_t        doneq[$];
    int           errq[$];
    logic [127:0] rdq[$];
    logic         rd_req = 1'b0;
    logic         rd_req_d = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Logical round k mapped to the index the port expects in this build.
    function automatic logic [3:0] ridx(input int k, input int nr);
        return c_DEC ? 4'(nr - k) : 4'(k);
    endfunction

    // Monitor: pops an expectation whenever the DUT presents done, err or read data.
    always @(negedge clk) begin
        done_t        e;
        int           ec;
        logic [127:0] er;
        if (rst_n) begin
            if (done) begin
                if (doneq.size() == 0) begin
                    chk("unexpected_done", 128'(done), 128'(0));
                end else begin
                    e = doneq.pop_front();
                    chk("done_cycle", 128'(cyc), 128'(e.cyc));
                    chk("nr_out_at_done", 128'(nr_out), 128'(e.nr));
                    chk("key_ready_at_done", 128'(key_ready), 128'(1));
                    chk("busy_at_done", 128'(busy), 128'(0));
                end
            end
            if (err) begin
                if (errq.size() == 0) begin
                    chk("unexpected_err", 128'(err), 128'(0));
                end else begin
                    ec = errq.pop_front();
                    chk("err_cycle", 128'(cyc), 128'(ec));
                end
            end
            if (rd_req_d) begin
                if (rdq.size() == 0) begin
                    chk("read_underflow", 128'(rdq.size()), 128'(1));
                end else begin
                    er = rdq.pop_front();
                    chk("rk_out", rk_out, er);
                end
            end
        end
    end

    task automatic do_start(input logic [1:0] len, input logic [255:0] key, input int lat, input int nr);
        key_len = len;
        key_in  = key;
        start   = 1'b1;
        if (lat > 0)
            doneq.push_back('{cyc + lat, nr});
        else
            errq.push_back(cyc + 1);
        @(negedge clk);
        start   = 1'b0;
        key_len = 2'b00;
        key_in  = ~key;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done)
            chk("done_timeout", 128'(done), 128'(1));
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
        rk_idx = idx;
        rd_req = 1'b1;
        rdq.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},      128'(busy),      128'(0));
        chk({tag, "_done"},      128'(done),      128'(0));
        chk({tag, "_key_ready"}, 128'(key_ready), 128'(0));
        chk({tag, "_err"},       128'(err),       128'(0));
        chk({tag, "_nr_out"},    128'(nr_out),    128'(0));
        chk({tag, "_rk_out"},    rk_out,          128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128 with junk in the unused low half of key_in
        do_start(2'b00, {c_K128, 128'hdeadbeefcafef00d0123456789abcdef}, 42, 10);
        rd(4'd0, 128'h0);
        wait_done(100);
        rd(ridx(0, 10), c_K128);
        rd(ridx(1, 10), c_R1_128);
        rd(ridx(2, 10), c_R2_128);
        rd(ridx(10, 10), c_R10_128);
        rd(4'd11, 128'h0);
        rd(4'd15, 128'h0);

        // AES-192
        do_start(2'b01, {c_K192, 64'hffffffffffffffff}, 48, 12);
        wait_done(100);
        rd(ridx(1, 12), c_R1_192);
        rd(ridx(12, 12), c_R12_192);
        rd(4'd13, 128'h0);

        // AES-256
        do_start(2'b10, c_K256, 54, 14);
        wait_done(100);
        rd(ridx(1, 14), c_R1_256);
        rd(ridx(2, 14), c_R2_256);
        rd(ridx(14, 14), c_R14_256);

        // Illegal key length leaves the AES-256 schedule untouched
        do_start(2'b11, {c_K128, 128'h0}, 0, 0);
        chk("illegal_busy", 128'(busy), 128'(0));
        chk("illegal_key_ready", 128'(key_ready), 128'(1));
        chk("illegal_nr_out", 128'(nr_out), 128'(14));
        rd(ridx(14, 14), c_R14_256);

        // Reset in the middle of an AES-256 expansion
        do_start(2'b10, c_K256, 54, 14);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        doneq.delete();
        #1;
        chk_idle_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'd0, 128'h0);

        // AES-128 again with start pulses while busy and at done
        do_start(2'b00, {c_K128, 128'h0}, 42, 10);
        repeat (4) @(negedge clk);
        start = 1'b1; key_len = 2'b10; key_in = c_K256;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; key_len = 2'b11;
        @(negedge clk);
        start = 1'b0;
        rd(ridx(10, 10), 128'h0);
        wait_done(100);
        start = 1'b1; key_len = 2'b10; key_in = c_K256;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_done_busy", 128'(busy), 128'(0));
        chk("start_at_done_key_ready", 128'(key_ready), 128'(1));
        rd(ridx(10, 10), c_R10_128);
        rd(ridx(0, 10), c_K128);
        rd(4'd15, 128'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(doneq.size() + errq.size() + rdq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
